npc_axi_master: RTL

//  - AXI4-Lite initiator bridging the NPC core's single-request memory port (IFU/LSU) to the
//    sim_sram responder. One outstanding transaction; reads use AR/R, writes use AW/W/B.
//  - Latches the request, drives the bus channels, returns rdata/err to the core as a 1-cycle pulse.

---
 rtl/npc_axi_pkg.sv | 22 ++
 rtl/npc_axi_master.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/npc_axi_pkg.sv
// Shared definitions for the NPC AXI4-Lite initiator: response codes and FSM states.
package npc_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_REQ  = 3'd3,
        WR_RESP = 3'd4
    } state_e;

    // SLVERR and DECERR are both reported to the core as a plain error.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
    endfunction

endpackage

// File: rtl/npc_axi_master.sv
// AXI4-Lite initiator for the NPC core memory port; one outstanding read or write.
// Optional feature: `NPC_AXI_ALIGN_CHECK_EN rejects misaligned requests without bus traffic.
module npc_axi_master
    import npc_axi_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64
) (
    input  logic                  aclk,
    input  logic                  areset,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wen,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_wstrb,
    input  logic [63:0]           req_pc,

    output logic                  resp_valid,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  resp_err,
    output logic [63:0]           pc,

    output logic [ADDR_W-1:0]     araddr,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_W-1:0]     rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready,

    output logic [ADDR_W-1:0]     awaddr,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [DATA_W-1:0]     wdata,
    output logic [DATA_W/8-1:0]   wstrb,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready
);

    localparam int unsigned STRB_W = DATA_W / 8;

    state_e state;
    logic   aw_done;
    logic   w_done;

    logic accept_c;
    logic misalign_c;
    logic aw_hs_c;
    logic w_hs_c;

    assign accept_c = req_valid & req_ready;
    assign aw_hs_c  = awvalid & awready;
    assign w_hs_c   = wvalid & wready;

`ifdef NPC_AXI_ALIGN_CHECK_EN
    assign misalign_c = (req_addr[2:0] != 3'b000);
`else
    assign misalign_c = 1'b0;
`endif

    // Transaction sequencer; every output is a flop updated here.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            pc         <= '0;
            araddr     <= '0;
            arvalid    <= 1'b0;
            rready     <= 1'b0;
            awaddr     <= '0;
            awvalid    <= 1'b0;
            wdata      <= '0;
            wstrb      <= STRB_W'(0);
            wvalid     <= 1'b0;
            bready     <= 1'b0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        pc <= req_pc;
                        if (misalign_c) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else if (req_wen) begin
                            state     <= WR_REQ;
                            req_ready <= 1'b0;
                            awaddr    <= req_addr;
                            wdata     <= req_wdata;
                            wstrb     <= req_wstrb;
                            awvalid   <= 1'b1;
                            wvalid    <= 1'b1;
                            aw_done   <= 1'b0;
                            w_done    <= 1'b0;
                        end else begin
                            state     <= RD_ADDR;
                            req_ready <= 1'b0;
                            araddr    <= req_addr;
                            arvalid   <= 1'b1;
                        end
                    end
                end
                RD_ADDR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (rvalid) begin
                        rready     <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_rdata <= rdata;
                        resp_err   <= resp_is_err(rresp);
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                WR_REQ: begin
                    // AW and W complete independently; leave once both have handshaken.
                    if (aw_hs_c) begin
                        awvalid <= 1'b0;
                        aw_done <= 1'b1;
                    end
                    if (w_hs_c) begin
                        wvalid <= 1'b0;
                        w_done <= 1'b1;
                    end
                    if ((aw_done | aw_hs_c) & (w_done | w_hs_c)) begin
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        bready  <= 1'b1;
                        state   <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (bvalid) begin
                        bready     <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= resp_is_err(bresp);
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
